bcd_to_binary_seq: RTL and testbench
====================================

# bcd_to_binary_seq

Sequential two-digit BCD-to-binary converter: the inverse of the adder's binary-to-BCD display path. It accepts a tens digit and a ones digit (each 0-9) and produces the 7-bit binary value using iterative shift-right/subtract-3 (reverse double-dabble). It has a start/busy/done handshake and flags invalid digits and values above a configurable limit. It sits between BCD operand entry (switches/keypad) and the 4-bit parallel adder's binary operand inputs.

## Interface
- MAX_VALUE, 31, largest value considered in range; a larger result sets `ovf`.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request conversion; sampled only in IDLE.
- ten_bcd  input  4  tens digit, valid 0-9; sampled with `start`.
- one_bcd  input  4  ones digit, valid 0-9; sampled with `start`.
- bin  output  7  binary result (0-99); holds until next result.
- busy  output  1  high from cycle after accepted `start` until DONE exits.
- done  output  1  one-cycle pulse; `bin`/`err`/`ovf` are valid and stable.
- err  output  1  last request had a digit > 9; held with `bin`.
- ovf  output  1  last valid result > MAX_VALUE; held with `bin`.

## Operation
- States: IDLE, SHIFT, DONE.
  - IDLE: `start`=1 with both digits ≤ 9:
    - load 15-bit shift register `sr = {ten_bcd, one_bcd, 7'b0}`;
    - clear the 3-bit iteration counter;
    - go to SHIFT.
  - IDLE: `start`=1 with either digit > 9:
    - `bin`<=0, `err`<=1, `ovf`<=0;
    - go to DONE.
  - SHIFT, each cycle:
    - shift `sr` right by 1, then subtract 3 from each 4-bit BCD field of the shifted value that is ≥ 8;
    - increment the counter;
    - after the 7th shift (counter==6 on entry): `bin`<=`sr[6:0]` of the shifted/corrected value, `err`<=0, `ovf`<=(result > MAX_VALUE); go to DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- Outputs `bin`, `err` and `ovf` are registered and change only on entry to DONE.
- `start` outside IDLE (SHIFT or DONE) is ignored, not queued.
- Digits need only be stable in the `start` cycle.
- Arithmetic: BCD fields stay 4 bits. Subtract-3 is applied only to fields ≥ 8, so there is no borrow or wrap. Result range is 0..99 in 7 bits.
- Reset values: state=IDLE, `sr`=0, counter=0, `bin`=0, `busy`=0, `done`=0, `err`=0, `ovf`=0.
- Reset mid-conversion aborts immediately: no `done` pulse, and outputs return to their reset values.

## Timing
- Valid request accepted in cycle 0: `busy`=1 in cycles 1-8; `done`=1 in cycle 8; `bin` valid from cycle 8.
- The next `start` can be accepted in cycle 9. Throughput is one conversion per 9 cycles.
- Invalid request in cycle 0: `busy`=1 and `done`=1 in cycle 1; IDLE in cycle 2.
- `busy` is high in DONE and low in IDLE.
- `done` never asserts twice for one request.
- `rst` and `start` high together: reset wins and the request is dropped.

## Test plan
- Basic conversion: `ten_bcd`=3, `one_bcd`=1, `start` pulsed in cycle 0 → `busy` high in cycles 1-8, `done`=1 in cycle 8 only, `bin`=7'd31, `err`=0, `ovf`=0.
- Overflow: 9,9 → `bin`=7'd99, `ovf`=1, `err`=0 at cycle 8. Then 0,0 → `bin`=0, `ovf`=0.
- Invalid digit: `ten_bcd`=4'hA, `one_bcd`=2 → `done` in cycle 1, `err`=1, `bin`=0, `ovf`=0. Then `ten_bcd`=1, `one_bcd`=4'hF → same response.
- Reset mid-conversion: start 2,7, assert `rst` in cycle 4 → all outputs 0 from cycle 5, no `done` pulse. A new start 1,5 then yields `bin`=15 eight cycles later.
- Start while busy: start 1,2, then pulse `start` with 8,8 in cycles 3 and 8 → single `done`, `bin`=12. A start in cycle 9 with 8,8 → `bin`=88, `ovf`=1 at cycle 17.
- Exhaustive sweep: every value 0..99 issued back-to-back at maximum rate → each `bin`=10·tens+ones, `ovf`=(value>31), `err`=0, one `done` per request.

Source files
------------

// File: rtl/bcd_to_binary_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_binary_seq_if
// Description : Request/result bundle for the sequential BCD-to-binary
//               converter: digit operands with start, binary result with flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_to_binary_seq_if;
    logic       start;
    logic [3:0] ten_bcd;
    logic [3:0] one_bcd;
    logic [6:0] bin;
    logic       busy;
    logic       done;
    logic       err;
    logic       ovf;

    modport master (
        output start, ten_bcd, one_bcd,
        input  bin, busy, done, err, ovf
    );

    modport slave (
        input  start, ten_bcd, one_bcd,
        output bin, busy, done, err, ovf
    );
endinterface
`default_nettype wire

// File: rtl/bcd_to_binary_seq.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_binary_seq
// Description : Two-digit BCD to 7-bit binary converter using iterative
//               shift-right / subtract-3 (reverse double-dabble).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_binary_seq #(
    parameter int MAX_VALUE = 31
) (
    input  wire logic            clk,
    input  wire logic            rst,
    bcd_to_binary_seq_if.slave   bus
);

    localparam logic [6:0] c_max_value  = MAX_VALUE[6:0];
    localparam logic [2:0] c_last_shift = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [14:0] r_sr;
    logic [2:0]  r_cnt;
    logic [6:0]  r_bin;
    logic        r_err;
    logic        r_ovf;

    logic [14:0] w_sr_shift;
    logic [14:0] w_sr_next;
    logic        w_digits_ok;
    logic        w_last;

    assign w_digits_ok = (bus.ten_bcd <= 4'd9) && (bus.one_bcd <= 4'd9);
    assign w_last      = (r_cnt == c_last_shift);
    assign w_sr_shift  = r_sr >> 1;

    // Correction happens after the shift, so a field >= 8 held a value that
    // absorbed half of the next-higher digit's weight (10/2 = 5 = 8 - 3).
    always_comb begin
        w_sr_next = w_sr_shift;
        if (w_sr_shift[14:11] >= 4'd8) begin
            w_sr_next[14:11] = w_sr_shift[14:11] - 4'd3;
        end
        if (w_sr_shift[10:7] >= 4'd8) begin
            w_sr_next[10:7] = w_sr_shift[10:7] - 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = w_digits_ok ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr  <= 15'd0;
            r_cnt <= 3'd0;
            r_bin <= 7'd0;
            r_err <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_digits_ok) begin
                            r_sr  <= {bus.ten_bcd, bus.one_bcd, 7'd0};
                            r_cnt <= 3'd0;
                        end else begin
                            r_bin <= 7'd0;
                            r_err <= 1'b1;
                            r_ovf <= 1'b0;
                        end
                    end
                end
                S_SHIFT: begin
                    r_sr  <= w_sr_next;
                    r_cnt <= r_cnt + 3'd1;
                    if (w_last) begin
                        r_bin <= w_sr_next[6:0];
                        r_err <= 1'b0;
                        r_ovf <= (w_sr_next[6:0] > c_max_value);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bin  = r_bin;
    assign bus.err  = r_err;
    assign bus.ovf  = r_ovf;
    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_binary_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_to_binary_seq
// Description : Directed self-checking bench for bcd_to_binary_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_to_binary_seq;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bcd_to_binary_seq_if bus ();

    bcd_to_binary_seq #(
        .MAX_VALUE (31)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every step lands 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [3:0] t, input logic [3:0] o);
        bus.start   = s;
        bus.ten_bcd = t;
        bus.one_bcd = o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 4'd0, 4'd0);
        tick();
        tick();
        checks++;
        if ({bus.bin, bus.busy, bus.done, bus.err, bus.ovf} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got bin=%0d busy=%b done=%b err=%b ovf=%b, want all 0",
                     bus.bin, bus.busy, bus.done, bus.err, bus.ovf);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        drive(1'b1, 4'd3, 4'd1);
        tick();
        drive(1'b0, 4'd0, 4'd0);
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== (c == 8)) begin
                errors++;
                $display("FAIL basic_handshake c%0d: busy=%b done=%b, want busy=1 done=%b",
                         c, bus.busy, bus.done, (c == 8));
            end
            if (c == 8) begin
                checks++;
                if (bus.bin !== 7'd31 || bus.err !== 1'b0 || bus.ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_result: bin=%0d err=%b ovf=%b, want 31 0 0",
                             bus.bin, bus.err, bus.ovf);
                end
            end
            tick();
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_overflow();
        drive(1'b1, 4'd9, 4'd9);
        tick();
        drive(1'b0, 4'd0, 4'd0);
        repeat (7) tick();
        checks++;
        if (bus.done !== 1'b1 || bus.bin !== 7'd99 || bus.ovf !== 1'b1 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_99: done=%b bin=%0d ovf=%b err=%b, want 1 99 1 0",
                     bus.done, bus.bin, bus.ovf, bus.err);
        end
        tick();
        drive(1'b1, 4'd0, 4'd0);
        tick();
        drive(1'b0, 4'd0, 4'd0);
        repeat (7) tick();
        checks++;
        if (bus.done !== 1'b1 || bus.bin !== 7'd0 || bus.ovf !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_00: done=%b bin=%0d ovf=%b err=%b, want 1 0 0 0",
                     bus.done, bus.bin, bus.ovf, bus.err);
        end
        tick();
    endtask

    task automatic test_invalid();
        logic [3:0] tens [2];
        logic [3:0] ones [2];
        tens[0] = 4'hA; ones[0] = 4'd2;
        tens[1] = 4'd1; ones[1] = 4'hF;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, tens[k], ones[k]);
            tick();
            drive(1'b0, 4'd0, 4'd0);
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b1 || bus.err !== 1'b1 ||
                bus.bin !== 7'd0 || bus.ovf !== 1'b0) begin
                errors++;
                $display("FAIL invalid_%0d: busy=%b done=%b err=%b bin=%0d ovf=%b, want 1 1 1 0 0",
                         k, bus.busy, bus.done, bus.err, bus.bin, bus.ovf);
            end
            tick();
            checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b1) begin
                errors++;
                $display("FAIL invalid_idle_%0d: busy=%b done=%b err=%b, want 0 0 1",
                         k, bus.busy, bus.done, bus.err);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int dn;
        dn = 0;
        drive(1'b1, 4'd1, 4'd2);
        tick();
        for (int c = 1; c <= 17; c++) begin
            if (c == 3 || c == 8 || c == 9) drive(1'b1, 4'd8, 4'd8);
            else                            drive(1'b0, 4'd0, 4'd0);
            if (bus.done === 1'b1) dn++;
            if (c == 8) begin
                checks++;
                if (bus.done !== 1'b1 || bus.bin !== 7'd12 || bus.ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_first: done=%b bin=%0d ovf=%b, want 1 12 0",
                             bus.done, bus.bin, bus.ovf);
                end
            end
            if (c == 16) begin
                checks++;
                if (dn !== 1) begin
                    errors++;
                    $display("FAIL busy_single_done: got %0d pulses, want 1", dn);
                end
            end
            if (c == 17) begin
                checks++;
                if (bus.done !== 1'b1 || bus.bin !== 7'd88 || bus.ovf !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_second: done=%b bin=%0d ovf=%b, want 1 88 1",
                             bus.done, bus.bin, bus.ovf);
                end
            end
            tick();
        end
        drive(1'b0, 4'd0, 4'd0);
    endtask

    task automatic test_reset_mid();
        int dn;
        drive(1'b1, 4'd2, 4'd7);
        tick();
        drive(1'b0, 4'd0, 4'd0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dn = 0;
        checks++;
        if ({bus.bin, bus.busy, bus.done, bus.err, bus.ovf} !== 11'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: bin=%0d busy=%b done=%b err=%b ovf=%b, want all 0",
                     bus.bin, bus.busy, bus.done, bus.err, bus.ovf);
        end
        for (int c = 5; c <= 12; c++) begin
            if (bus.done === 1'b1) dn++;
            tick();
        end
        checks++;
        if (dn !== 0) begin
            errors++;
            $display("FAIL rstmid_no_done: got %0d pulses, want 0", dn);
        end
        // Reset and start together: request must be dropped.
        rst = 1'b1;
        drive(1'b1, 4'd5, 4'd5);
        tick();
        rst = 1'b0;
        drive(1'b0, 4'd0, 4'd0);
        dn = 0;
        for (int c = 1; c <= 9; c++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) dn++;
            tick();
        end
        checks++;
        if (dn !== 0) begin
            errors++;
            $display("FAIL rst_start_drop: busy/done seen %0d cycles, want 0", dn);
        end
        drive(1'b1, 4'd1, 4'd5);
        tick();
        drive(1'b0, 4'd0, 4'd0);
        repeat (7) tick();
        checks++;
        if (bus.done !== 1'b1 || bus.bin !== 7'd15 || bus.ovf !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_restart: done=%b bin=%0d ovf=%b err=%b, want 1 15 0 0",
                     bus.done, bus.bin, bus.ovf, bus.err);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int dn;
        int v;
        for (int t = 0; t <= 9; t++) begin
            for (int o = 0; o <= 9; o++) begin
                v = 10 * t + o;
                drive(1'b1, 4'(t), 4'(o));
                tick();
                drive(1'b0, 4'd0, 4'd0);
                dn = 0;
                for (int c = 1; c <= 8; c++) begin
                    if (bus.done === 1'b1) dn++;
                    if (c == 8) begin
                        checks++;
                        if (bus.bin !== 7'(v) || bus.ovf !== (v > 31) || bus.err !== 1'b0) begin
                            errors++;
                            $display("FAIL sweep_%0d: bin=%0d ovf=%b err=%b, want %0d %b 0",
                                     v, bus.bin, bus.ovf, bus.err, v, (v > 31));
                        end
                    end
                    tick();
                end
                checks++;
                if (dn !== 1) begin
                    errors++;
                    $display("FAIL sweep_done_%0d: got %0d pulses, want 1", v, dn);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_invalid();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
